// File: rtl/hyperbus_arbiter.sv
// Round-robin arbiter sharing one Hyperbus native controller port between
// NPORTS requesters. A grant is held for a whole transaction. Address and
// request type are latched at grant. Data and handshakes are steered
// combinationally between the granted port and the controller. A watchdog
// releases a port that stalls mid-transaction and pulses m_err for it.
//
// Handshake semantics: a requester raises m_rrq/m_wrq and holds it, with a
// stable m_adr_i, until its last beat has been accepted. Each cycle in which
// m_ready[i] (write) or m_valid[i] (read) is high moves exactly one data beat.
// Dropping the request ends the transaction, and the controller sees
// hbus_rrq/hbus_wrq low in that same cycle.
module hyperbus_arbiter #(
    parameter int NPORTS     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         hbus_clk,
    input  logic                         hbus_rst,
    input  logic [NPORTS-1:0]            m_rrq,
    input  logic [NPORTS-1:0]            m_wrq,
    input  logic [NPORTS*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [NPORTS*DATA_WIDTH-1:0] m_dat_i,
    output logic [DATA_WIDTH-1:0]        m_dat_o,
    output logic [NPORTS-1:0]            m_gnt,
    output logic [NPORTS-1:0]            m_ready,
    output logic [NPORTS-1:0]            m_valid,
    output logic [NPORTS-1:0]            m_err,
    output logic [ADDR_WIDTH-1:0]        hbus_adr_o,
    output logic [DATA_WIDTH-1:0]        hbus_dat_o,
    output logic                         hbus_rrq,
    output logic                         hbus_wrq,
    input  logic [DATA_WIDTH-1:0]        hbus_dat_i,
    input  logic                         hbus_ready,
    input  logic                         hbus_valid,
    input  logic                         hbus_busy
);

    localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NPORTS - 1);

    // One-hot state encoding.
    typedef enum logic [2:0] {
        S_IDLE   = 3'b001,
        S_ACTIVE = 3'b010,
        S_DRAIN  = 3'b100
    } state_t;

    state_t                  state_q;
    logic [NPORTS-1:0]       gnt_q;
    logic [IDX_W-1:0]        gidx_q;
    logic [IDX_W-1:0]        last_q;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    is_wr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NPORTS-1:0]       err_q;

    logic [NPORTS-1:0]       req_any;
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand;
    logic [NPORTS-1:0]       pick_oh;
    logic [ADDR_WIDTH-1:0]   pick_adr;
    logic                    pick_wr;
    logic                    g_rrq;
    logic                    g_wrq;
    logic                    g_req;
    logic                    active;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   dat_mux;

    assign req_any = m_rrq | m_wrq;
    assign active  = (state_q == S_ACTIVE);
    assign stall   = ~hbus_ready & ~hbus_valid;

    // Request lines of the granted port; only the latched type keeps the
    // transaction alive.
    assign g_rrq = m_rrq[gidx_q];
    assign g_wrq = m_wrq[gidx_q];
    assign g_req = is_wr_q ? g_wrq : g_rrq;

    // Round-robin search: first requester starting at last+1, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        pick_oh    = '0;
        pick_adr   = '0;
        pick_wr    = 1'b0;
        cand       = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NPORTS);
            if (!pick_found && req_any[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
                pick_oh    = NPORTS'(1) << cand;
                pick_adr   = m_adr_i[int'(cand)*ADDR_WIDTH +: ADDR_WIDTH];
                // Read wins when a port raises both request lines.
                pick_wr    = ~m_rrq[cand] & m_wrq[cand];
            end
        end
    end

    // Write data mux selected by the registered one-hot grant.
    always_comb begin
        dat_mux = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (gnt_q[i]) begin
                dat_mux = dat_mux | m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Controller-side requests exist only in ACTIVE, so the async reset and
    // the drop of the granted request both clear them immediately.
    assign hbus_rrq   = active & g_rrq & ~is_wr_q;
    assign hbus_wrq   = active & g_wrq &  is_wr_q;
    assign hbus_adr_o = adr_q;
    assign hbus_dat_o = dat_mux;

    // Handshakes go to the granted port only, and only for the latched type.
    assign m_ready = (active & is_wr_q  & hbus_ready) ? gnt_q : '0;
    assign m_valid = (active & ~is_wr_q & hbus_valid) ? gnt_q : '0;
    assign m_dat_o = hbus_dat_i;
    assign m_gnt   = gnt_q;
    assign m_err   = err_q;

    // Arbitration FSM with grant, address, type, watchdog and error pulse.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            adr_q   <= '0;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            err_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_found && !hbus_busy) begin
                        gnt_q   <= pick_oh;
                        gidx_q  <= pick_idx;
                        last_q  <= pick_idx;
                        adr_q   <= pick_adr;
                        is_wr_q <= pick_wr;
                        cnt_q   <= '0;
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (!g_req) begin
                        // Normal end of transaction.
                        state_q <= S_DRAIN;
                    end else if (!stall) begin
                        cnt_q <= '0;
                    end else if (WD_EN) begin
                        // Saturating count of consecutive stall cycles; the
                        // TIMEOUT-th one releases the port.
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                            err_q   <= gnt_q;
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Hold the grant until the controller has gone idle.
                    if (!hbus_busy) begin
                        gnt_q   <= '0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    gnt_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/hyperbus_arbiter.md
# hyperbus_arbiter

Round-robin arbiter that shares one Hyperbus native memory interface (controller side, `hbus_clk` domain) between `NPORTS` requesters, e.g. several `hyperbus_fifo` instances or a DMA engine. It locks a grant for a whole transaction, steers address, write data and handshakes to and from the granted port, and waits for the controller to go idle before re-arbitrating. A watchdog releases a port that stalls mid-transaction and flags an error.

## Interface
- `NPORTS`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 32: Hyperbus address width.
- `DATA_WIDTH`, 16: Hyperbus data width.
- `TIMEOUT`, 1024: ACTIVE cycles allowed without `hbus_ready`/`hbus_valid` before forced release; 0 disables.

Ports:
- `hbus_clk`  in  1  clock.
- `hbus_rst`  in  1  reset, asynchronous, active-high.
- `m_rrq`  in  NPORTS  per-port read request.
- `m_wrq`  in  NPORTS  per-port write request.
- `m_adr_i`  in  NPORTS*ADDR_WIDTH  per-port address, port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `m_dat_i`  in  NPORTS*DATA_WIDTH  per-port write data, same packing.
- `m_dat_o`  out  DATA_WIDTH  read data, broadcast (= `hbus_dat_i`).
- `m_gnt`  out  NPORTS  one-hot grant, registered.
- `m_ready`  out  NPORTS  `hbus_ready` steered to the granted write port.
- `m_valid`  out  NPORTS  `hbus_valid` steered to the granted read port.
- `m_err`  out  NPORTS  one-cycle pulse: port i released by the watchdog.
- `hbus_adr_o`  out  ADDR_WIDTH  address to controller, registered at grant.
- `hbus_dat_o`  out  DATA_WIDTH  write data, combinational mux of `m_dat_i` of the granted port.
- `hbus_rrq`, `hbus_wrq`  out  1  requests to controller.
- `hbus_dat_i`  in  DATA_WIDTH  read data.
- `hbus_ready`, `hbus_valid`, `hbus_busy`  in  1  controller handshakes.

## Operation
- State machine, one-hot: IDLE, ACTIVE, DRAIN.
- IDLE: if `|(m_rrq|m_wrq)` and `~hbus_busy`: choose the first requesting port, searching from `last+1` modulo NPORTS. Register `gnt`, `last <= i`, `hbus_adr_o <= m_adr_i[i]`, `is_wr <= ~m_rrq[i] & m_wrq[i]` (read wins if both are set). Go to ACTIVE. With `hbus_busy` high, stay in IDLE and grant nothing.
- ACTIVE: `hbus_rrq = m_rrq[g] & ~is_wr`; `hbus_wrq = m_wrq[g] & is_wr`. The request type is latched, so the other request line of the port is ignored. `m_ready[g] = hbus_ready & is_wr`; `m_valid[g] = hbus_valid & ~is_wr`. All non-granted `m_ready`/`m_valid` are 0.
  - When the latched-type request of the granted port drops: go to DRAIN, `hbus_rrq`/`hbus_wrq` are 0 from that cycle on.
  - Watchdog: counter cleared on grant and on any `hbus_ready`/`hbus_valid`, incremented otherwise. When it reaches TIMEOUT: pulse `m_err[g]`, go to DRAIN.
- DRAIN: requests to controller forced to 0, `m_gnt` still asserted. When `hbus_busy` is low: clear `m_gnt`, go to IDLE. A new grant is possible no earlier than the next cycle.
- A requester must hold its request until its last beat and must not change `m_adr_i` while granted.
- Reset values: `m_gnt`=0, `hbus_rrq`=`hbus_wrq`=0, `hbus_adr_o`=0, `m_ready`=`m_valid`=`m_err`=0, `last`=NPORTS-1 (port 0 wins first), state IDLE, counter 0.
- Reset mid-transaction drops all requests immediately, asynchronously; the controller is expected to abort on `hbus_rrq`/`hbus_wrq` low.

## Timing
- Request seen in IDLE at edge N -> `m_gnt`, `hbus_adr_o` valid after N; `hbus_rrq`/`hbus_wrq` high in cycle N+1. Arbitration latency: 1 cycle.
- ACTIVE data and handshake paths are combinational, with zero added latency per beat.
- Release: request low in cycle K -> DRAIN from K+1. Minimum gap between grants is 1 DRAIN cycle plus 1 IDLE cycle, plus however long `hbus_busy` stays high.
- Watchdog fires on the TIMEOUT-th consecutive stall cycle. `m_err` is high exactly 1 cycle.
- Counter width: `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Test plan
- Single port 0 read to 0x0000_0100: `m_rrq[0]` high for 2 `hbus_valid` beats -> `m_gnt`=01 one cycle later, `hbus_adr_o`=0x100, `m_valid[0]` mirrors `hbus_valid`, `m_valid[1]`=0. Then DRAIN -> IDLE once `hbus_busy` falls.
- Both ports request continuously, 4 transactions each -> grants alternate 0,1,0,1,…, starting at port 0. No grant is issued while `hbus_busy`=1.
- Port 1 asserts `m_rrq` and `m_wrq` together -> read is issued, `hbus_wrq`=0 for the whole grant, `m_ready[1]`=0.
- Port 0 write with data 0xA5A5 -> `hbus_dat_o`=0xA5A5 while granted. Port 1 data 0x5A5A never appears on `hbus_dat_o` during port 0's grant.
- TIMEOUT=8, port 0 holds `m_wrq` with no `hbus_ready` -> `m_err[0]` pulses on the 8th stall cycle, `hbus_wrq` drops, and port 1's pending request is granted after `hbus_busy` falls.
- Assert `hbus_rst` during ACTIVE -> `hbus_rrq`/`hbus_wrq`/`m_gnt` are 0 the same cycle. After release, port 0 is granted first.
